// File: rtl/mixcolumns_iter.sv
// mixcolumns_iter: folded AES MixColumns engine with a valid/ready handshake on each side.
// Transforms LANES columns per cycle in place, so a 128-bit block takes 4/LANES cycles.
// Optional feature: define MIXCOL_INV_EN to honour in_inv (InvMixColumns); otherwise
// the engine is forward-only and in_inv is ignored.

module mixcolumns_iter #(
   parameter int unsigned LANES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   // Elaboration-time guard on the fold factor.
   if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
      $error("mixcolumns_iter: LANES must be 1, 2 or 4");
   end

   localparam int unsigned NCYC = 4 / LANES;
   localparam logic [1:0]  LAST = 2'(NCYC - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e            state_q, state_d;
   // Column c of the block lives in work_q[3-c], so column 0 is the MSB word.
   logic [3:0][31:0]  work_q, work_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              inv_q;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Forward column mix: 02 03 01 01 circulant.
   function automatic logic [31:0] mix_fwd(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] r0, r1, r2, r3;
      {a0, a1, a2, a3} = col;
      r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      return {r0, r1, r2, r3};
   endfunction

`ifdef MIXCOL_INV_EN
   // Inverse column mix: 0E 0B 0D 09 circulant, multiples built from x2/x4/x8.
   function automatic logic [31:0] mix_inv(input logic [31:0] col);
      logic [7:0] a [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      {a[0], a[1], a[2], a[3]} = col;
      for (int i = 0; i < 4; i++) begin
         x2    = xtime(a[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction
`endif

   // Lane transform; the mode mux only exists when inverse support is built in.
   function automatic logic [31:0] xform(input logic [31:0] col, input logic inv);
`ifdef MIXCOL_INV_EN
      return inv ? mix_inv(col) : mix_fwd(col);
`else
      logic unused_mode;
      unused_mode = inv;
      return mix_fwd(col);
`endif
   endfunction

   // Next-state, working-register update and handshake outputs.
   always_comb begin
      logic [1:0] idx;
      state_d   = state_q;
      work_d    = work_q;
      cnt_d     = cnt_q;
      idx       = '0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               work_d  = in_data;
               cnt_d   = '0;
               state_d = StBusy;
            end
         end
         StBusy: begin
            for (int unsigned l = 0; l < LANES; l++) begin
               idx          = 2'(cnt_q * LANES + l);
               work_d[~idx] = xform(work_q[~idx], inv_q);
            end
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == LAST) begin
               state_d = StDone;
            end
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign out_data = work_q;

   // State, working register and column counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         work_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef MIXCOL_INV_EN
   // Mode is sampled only when a block is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inv_q <= 1'b0;
      end else if (state_q == StIdle && in_valid) begin
         inv_q <= in_inv;
      end
   end
`else
   logic unused_in_inv;
   assign unused_in_inv = in_inv;
   assign inv_q         = 1'b0;
`endif

endmodule

// File: tb/tb_mixcolumns_iter.sv
// Self-checking bench for mixcolumns_iter: one instance each of LANES = 1, 2, 4,
// compared against a GF(2^8) matrix reference model.

module tb_mixcolumns_iter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         vld  [3];
   logic         rdy  [3];
   logic         inv  [3];
   logic         ov   [3];
   logic         ordy [3];
   logic         bsy  [3];
   logic [127:0] din  [3];
   logic [127:0] dout [3];

   int errors = 0;
   int checks = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mixcolumns_iter #(.LANES(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (vld[g]),
         .in_ready  (rdy[g]),
         .in_data   (din[g]),
         .in_inv    (inv[g]),
         .out_valid (ov[g]),
         .out_ready (ordy[g]),
         .out_data  (dout[g]),
         .busy      (bsy[g])
      );
   end

   function automatic int nsteps(input int k);
      return (k == 0) ? 4 : ((k == 1) ? 2 : 1);
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
      for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
      return p[7:0];
   endfunction

   // Reference: each column multiplied by a circulant matrix over GF(2^8).
   function automatic logic [127:0] model(input logic [127:0] blk, input logic iv);
      logic [7:0]   coef [4];
      logic [7:0]   a    [4];
      logic [7:0]   r;
      logic [127:0] res;
      logic         eff;
`ifdef MIXCOL_INV_EN
      eff = iv;
`else
      eff = 1'b0;
`endif
      if (eff) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
      res = '0;
      for (int c = 0; c < 4; c++) begin
         for (int j = 0; j < 4; j++) a[j] = 8'(blk >> (120 - 32 * c - 8 * j));
         for (int i = 0; i < 4; i++) begin
            r = 8'h00;
            for (int j = 0; j < 4; j++) r = r ^ gmul(coef[(j - i) & 3], a[j]);
            res = res | (128'(r) << (120 - 32 * c - 8 * i));
         end
      end
      return res;
   endfunction

   // Offers one block to instance k and waits (bounded) for out_valid; out_ready held low.
   // Inputs are scrambled after acceptance to show they are only sampled once.
   task automatic run_block(input int k, input logic [127:0] d, input logic iv,
                            output int lat, output logic was_rdy);
      @(negedge clk);
      was_rdy = rdy[k];
      ordy[k] = 1'b0;
      din[k]  = d;
      inv[k]  = iv;
      vld[k]  = 1'b1;
      lat     = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         vld[k] = 1'b0;
         inv[k] = ~iv;
         din[k] = ~d;
         lat++;
         if (ov[k]) break;
      end
   endtask

   // Completes the output handshake; returns at the negedge after the edge.
   task automatic release_block(input int k);
      ordy[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ordy[k] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({rdy[k], ov[k], bsy[k]} !== 3'b100 || dout[k] !== '0) begin
            errors++;
            $display("FAIL reset[%0d]: rdy/ov/busy=%b%b%b data=%h, want 100 data=0",
                     k, rdy[k], ov[k], bsy[k], dout[k]);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_forward();
      int lat;
      logic r0;
      logic [127:0] d, e;
      for (int k = 0; k < 3; k++) begin
         run_block(k, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, lat, r0);
         checks++;
         if (dout[k] !== 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6) begin
            errors++;
            $display("FAIL fwd_vec[%0d]: got %h", k, dout[k]);
         end
         checks++;
         if (lat !== nsteps(k) + 1 || r0 !== 1'b1) begin
            errors++;
            $display("FAIL fwd_latency[%0d]: lat=%0d rdy=%b want lat=%0d rdy=1",
                     k, lat, r0, nsteps(k) + 1);
         end
         release_block(k);
         checks++;
         if (rdy[k] !== 1'b1 || ov[k] !== 1'b0) begin
            errors++;
            $display("FAIL fwd_release[%0d]: rdy=%b ov=%b want 1 0", k, rdy[k], ov[k]);
         end
         for (int n = 0; n < 4; n++) begin
            d = rand128();
            e = model(d, 1'b0);
            run_block(k, d, 1'b0, lat, r0);
            checks++;
            if (dout[k] !== e) begin
               errors++;
               $display("FAIL fwd_rand[%0d]: in=%h got %h want %h", k, d, dout[k], e);
            end
            release_block(k);
         end
      end
   endtask

   task automatic test_inverse();
      int lat;
      logic r0;
      logic iv;
      logic [127:0] d, e;
`ifdef MIXCOL_INV_EN
      e = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
`else
      e = model(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0);
`endif
      for (int k = 0; k < 3; k++) begin
         run_block(k, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1, lat, r0);
         checks++;
         if (dout[k] !== e || lat !== nsteps(k) + 1) begin
            errors++;
            $display("FAIL inv_vec[%0d]: got %h lat=%0d want %h lat=%0d",
                     k, dout[k], lat, e, nsteps(k) + 1);
         end
         release_block(k);
         for (int n = 0; n < 4; n++) begin
            d  = rand128();
            iv = 1'($urandom_range(0, 1));
            run_block(k, d, iv, lat, r0);
            checks++;
            if (dout[k] !== model(d, iv)) begin
               errors++;
               $display("FAIL inv_rand[%0d]: in=%h inv=%b got %h want %h",
                        k, d, iv, dout[k], model(d, iv));
            end
            release_block(k);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic r0;
      logic [127:0] e;
      e = {4{32'hd5d5d7d6}};
      run_block(1, {4{32'hd4d4d4d5}}, 1'b0, lat, r0);
      checks++;
      if (dout[1] !== e || lat !== 3) begin
         errors++;
         $display("FAIL bp_result: got %h lat=%0d want %h lat=3", dout[1], lat, e);
      end
      for (int i = 0; i < 5; i++) begin
         vld[1] = 1'b1;
         din[1] = rand128();
         inv[1] = ~inv[1];
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (dout[1] !== e || rdy[1] !== 1'b0 || ov[1] !== 1'b1 || bsy[1] !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold[%0d]: data=%h rdy=%b ov=%b busy=%b", i, dout[1], rdy[1],
                     ov[1], bsy[1]);
         end
      end
      vld[1] = 1'b0;
      release_block(1);
      checks++;
      if (rdy[1] !== 1'b1 || ov[1] !== 1'b0 || bsy[1] !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: rdy=%b ov=%b busy=%b want 1 0 0", rdy[1], ov[1], bsy[1]);
      end
   endtask

   task automatic test_midreset();
      int lat;
      logic r0;
      logic saw_ov;
      @(negedge clk);
      din[0] = rand128();
      inv[0] = 1'b0;
      vld[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vld[0] = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || dout[0] !== '0) begin
         errors++;
         $display("FAIL midreset_async: rdy=%b busy=%b data=%h want 1 0 0",
                  rdy[0], bsy[0], dout[0]);
      end
      saw_ov = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ov[0]) saw_ov = 1'b1;
      end
      checks++;
      if (saw_ov !== 1'b0) begin
         errors++;
         $display("FAIL midreset_no_output: out_valid=%b want 0", saw_ov);
      end
      run_block(0, {4{32'h2d26314c}}, 1'b0, lat, r0);
      checks++;
      if (dout[0] !== {4{32'h4d7ebdf8}} || lat !== 5) begin
         errors++;
         $display("FAIL midreset_after: got %h lat=%0d want %h lat=5",
                  dout[0], lat, {4{32'h4d7ebdf8}});
      end
      release_block(0);
   endtask

   task automatic test_back_to_back();
      logic [127:0] q[$];
      logic [127:0] e;
      int last = -1;
      int acc = 0;
      int got = 0;
      logic pend = 1'b0;
      @(negedge clk);
      din[2]  = rand128();
      inv[2]  = 1'($urandom_range(0, 1));
      vld[2]  = 1'b1;
      ordy[2] = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (ov[2]) begin
            e = (q.size() > 0) ? q.pop_front() : ~dout[2];
            got++;
            checks++;
            if (dout[2] !== e) begin
               errors++;
               $display("FAIL b2b_data[%0d]: got %h want %h", got, dout[2], e);
            end
         end
         if (rdy[2]) begin
            if (last >= 0) begin
               checks++;
               if (cyc - last !== 3) begin
                  errors++;
                  $display("FAIL b2b_spacing: gap=%0d want 3", cyc - last);
               end
            end
            last = cyc;
            q.push_back(model(din[2], inv[2]));
            acc++;
            pend = 1'b1;
         end
         @(posedge clk);
         @(negedge clk);
         if (pend) begin
            din[2] = rand128();
            inv[2] = 1'($urandom_range(0, 1));
            pend   = 1'b0;
         end
      end
      vld[2] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (ov[2]) begin
            e = (q.size() > 0) ? q.pop_front() : ~dout[2];
            got++;
            checks++;
            if (dout[2] !== e) begin
               errors++;
               $display("FAIL b2b_drain: got %h want %h", dout[2], e);
            end
         end
         @(posedge clk);
         @(negedge clk);
      end
      ordy[2] = 1'b0;
      checks++;
      if (got !== acc || acc < 12) begin
         errors++;
         $display("FAIL b2b_count: outputs=%0d accepted=%0d want equal and >=12", got, acc);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         vld[k]  = 1'b0;
         inv[k]  = 1'b0;
         ordy[k] = 1'b0;
         din[k]  = '0;
      end
      test_reset();
      test_forward();
      test_inverse();
      test_backpressure();
      test_midreset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mixcolumns_iter.md
# mixcolumns_iter

Iterative, handshaked AES MixColumns engine. Transforms a 128-bit state over 4/LANES cycles, processing LANES columns per cycle, in forward or (optionally) inverse mode. It replaces the purely combinational four-column array in the round datapath wherever area or timing favours a folded implementation. It sits between ShiftRows and AddRoundKey in the round pipeline.

## Interface
Parameters:
- LANES, default 4: columns processed per cycle. Legal values are 1, 2 and 4; any other value causes an elaboration-time `$error`.

Ports:
- clk  input  1  clock; all state is updated on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  in_data and in_inv are valid.
- in_ready  output  1  the engine can accept a block; high only in IDLE.
- in_data  input  128  input state. Column c = in_data[127-32c -: 32]; row 0 is the MSB byte of each column.
- in_inv  input  1  0 = forward MixColumns, 1 = InvMixColumns.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  the downstream stage accepts out_data.
- out_data  output  128  result, using the same byte layout as in_data.
- busy  output  1  high in BUSY or DONE.

## Operation
State machine: IDLE -> BUSY -> DONE -> IDLE.
- **IDLE:**
  - in_ready=1.
  - When in_valid && in_ready: capture in_data into a 128-bit working register, latch in_inv, clear the column counter, go to BUSY.
- **BUSY:**
  - Each cycle, replace columns [cnt*LANES .. cnt*LANES+LANES-1] in place with their transformed values, then increment cnt.
  - After N = 4/LANES cycles, go to DONE.
  - in_valid is ignored.
- **DONE:**
  - out_valid=1; out_data shows the working register.
  - out_data stays stable while out_ready=0.
  - When out_ready=1: go to IDLE.

Column transform (GF(2^8), polynomial 0x11B, xtime = {b[6:0],0} ^ (b[7] ? 8'h1B : 0)):
- Forward: r0 = 2a0^3a1^a2^a3, with rows rotated for r1..r3 (matrix 02 03 01 01 circulant).
- Inverse: matrix 0E 0B 0D 09 circulant, built from repeated xtime.
- All arithmetic is 8-bit XOR; there is no carry and no widening.

Outputs and registers:
- out_data is the working register directly, not a separate copy.
- in_inv is sampled only at acceptance; changes during BUSY or DONE have no effect.

## Timing
- **Reset:** async assertion forces IDLE from any state, including mid-BUSY and DONE. Working register=0, cnt=0, latched mode=0.
- **Reset values of outputs:** in_ready=1 (IDLE), out_valid=0, out_data=0, busy=0.
- **Latency:** acceptance edge E0; out_valid rises after edge E_N, where N = 1, 2 or 4 for LANES = 4, 2 or 1.
- **Throughput:** with out_ready held high, one block every N+2 cycles. There is no overlap: in_ready=0 from E0 until the edge after the output handshake.
- **Backpressure:** DONE is held indefinitely; out_data does not change.
- **Simultaneous events:** in_valid during DONE with out_ready=1 is not accepted in that cycle. It is accepted on the first IDLE cycle.

## Configuration
- MIXCOL_INV_EN defined:
  - in_inv is honoured.
  - Inverse-matrix logic is present for each lane.
- MIXCOL_INV_EN undefined:
  - The inverse logic is removed.
  - in_inv is ignored, and the latched mode is tied to 0 (always forward).
  - The port remains in the interface.

## Test plan
1. **Reset:** rst_n=0 for 3 cycles -> in_ready=1, out_valid=0, busy=0, out_data=0.
2. **Forward, LANES=4:** in_data=128'hdb135345_f20a225c_01010101_c6c6c6c6, in_inv=0 -> after 1 cycle out_data=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6.
3. **Inverse, LANES=1, MIXCOL_INV_EN defined:** in_data=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, in_inv=1 -> after 4 cycles out_data=128'hdb135345_f20a225c_01010101_c6c6c6c6. Without the macro the same stimulus yields the forward result.
4. **Backpressure, LANES=2:** column d4d4d4d5 in all 4 columns, out_ready=0 for 5 cycles -> out_data=d5d5d7d6 repeated, stable, and in_ready=0 throughout. out_ready=1 -> IDLE on the next edge.
5. **Mid-operation reset:** deassert rst_n during BUSY cycle 2 with LANES=1 -> IDLE immediately, out_valid never asserts. A subsequent input 2d26314c×4 yields 4d7ebdf8×4.
6. **Back-to-back:** LANES=4, in_valid held high with out_ready=1 -> acceptances exactly 3 cycles apart, each result correct.
